// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Fetch front end: PC register, direct-mapped BTB with 2-bit counters, redirect/flush.
`ifndef STALL_WIDTH
`define STALL_WIDTH 2
`endif
`ifndef STALL_NONE
`define STALL_NONE 2'd0
`endif
`ifndef STALL_LOAD
`define STALL_LOAD 2'd1
`endif
`ifndef STALL_BRANCH
`define STALL_BRANCH 2'd2
`endif

module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`STALL_WIDTH-1:0] stall,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic                    upd_taken,
  input  logic [31:0]             upd_target,
  output logic [31:0]             imem_addr,
  input  logic [31:0]             imem_rdata,
  output logic [31:0]             PC_if,
  output logic [31:0]             inst_if,
  output logic                    bp_if,
  output logic [31:0]             BTB_target_if,
  output logic                    flush
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;

  logic [31:0]            pc_q;
  logic [31:0]            next_pc;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TW-1:0]          tag_q [BTB_ENTRIES];
  logic [31:0]            tgt_q [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];

  logic [IDX-1:0] rd_idx;
  logic           rd_hit;
  logic [IDX-1:0] wr_idx;
  logic [TW-1:0]  wr_tag;
  logic           wr_hit;
  logic           freeze;
  logic           unused_bits;

  assign unused_bits = ^{redirect_pc[1:0], upd_pc[1:0]};

  // Lookup reads the registered arrays, so a same-cycle update is not visible yet.
  assign rd_idx        = pc_q[IDX+1:2];
  assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == pc_q[31:IDX+2]);
  assign bp_if         = rd_hit && ctr_q[rd_idx][1];
  assign BTB_target_if = bp_if ? tgt_q[rd_idx] : 32'h0;

  assign PC_if     = pc_q;
  assign imem_addr = pc_q;
  assign inst_if   = imem_rdata;
  assign flush     = redirect_valid;

  assign freeze = (stall == `STALL_LOAD) || (stall == `STALL_BRANCH);

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (redirect_valid) begin
      next_pc = {redirect_pc[31:2], 2'b00};
    end else if (freeze) begin
      next_pc = pc_q;
    end else if (bp_if) begin
      next_pc = BTB_target_if;
    end
  end

  assign wr_idx = upd_pc[IDX+1:2];
  assign wr_tag = upd_pc[31:IDX+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      pc_q <= next_pc;
      if (upd_valid) begin
        if (wr_hit) begin
          if (upd_taken) begin
            if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
            tgt_q[wr_idx] <= upd_target;
          end else if (ctr_q[wr_idx] != 2'b00) begin
            ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
          end
        end else if (upd_taken) begin
          // Miss-taken overwrites whatever aliased into this slot, starting weakly taken.
          valid_q[wr_idx] <= 1'b1;
          tag_q[wr_idx]   <= wr_tag;
          tgt_q[wr_idx]   <= upd_target;
          ctr_q[wr_idx]   <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Directed self-checking bench for fetch_unit.
`ifndef STALL_WIDTH
`define STALL_WIDTH 2
`endif
`ifndef STALL_NONE
`define STALL_NONE 2'd0
`endif
`ifndef STALL_LOAD
`define STALL_LOAD 2'd1
`endif
`ifndef STALL_BRANCH
`define STALL_BRANCH 2'd2
`endif

module tb_fetch_unit;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [`STALL_WIDTH-1:0] stall;
  logic                    redirect_valid;
  logic [31:0]             redirect_pc;
  logic                    upd_valid;
  logic [31:0]             upd_pc;
  logic                    upd_taken;
  logic [31:0]             upd_target;
  logic [31:0]             imem_addr;
  logic [31:0]             imem_rdata;
  logic [31:0]             PC_if;
  logic [31:0]             inst_if;
  logic                    bp_if;
  logic [31:0]             BTB_target_if;
  logic                    flush;
  logic                    stall_viol;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: the word is the inverted address.
  assign imem_rdata = ~imem_addr;
  // Hazard-unit contract: no freezing stall in a redirect cycle.
  assign stall_viol = redirect_valid && ((stall == `STALL_LOAD) || (stall == `STALL_BRANCH));

  fetch_unit #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PC_if(PC_if), .inst_if(inst_if), .bp_if(bp_if), .BTB_target_if(BTB_target_if),
    .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc);
    #1;
    check(tag, PC_if, pc);
  endtask

  task automatic chk_bp(input string tag, input logic bp, input logic [31:0] tgt);
    #1;
    check({tag, "_bp"}, {31'h0, bp_if}, {31'h0, bp});
    check({tag, "_tgt"}, BTB_target_if, tgt);
  endtask

  task automatic go(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = `STALL_NONE; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    tick();
    chk_pc("reset_pc", 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    chk_bp("reset", 1'b0, 32'h0);
    check("reset_flush", {31'h0, flush}, 32'h0);
    check("reset_inst", inst_if, 32'hFFFF_FFFF);

    rst = 1'b0;
    chk_pc("seq0", 32'h0);
    tick(); chk_pc("seq4", 32'h4);
    tick(); chk_pc("seq8", 32'h8);
    chk_bp("seq8", 1'b0, 32'h0);
    tick(); chk_pc("seq12", 32'hC);
    check("seq12_inst", inst_if, 32'hFFFF_FFF3);
    tick(); chk_pc("seq16", 32'h10);

    stall = `STALL_LOAD;
    tick(); chk_pc("load_hold1", 32'h10);
    tick(); stall = `STALL_NONE; chk_pc("load_hold2", 32'h10);
    tick(); chk_pc("load_release", 32'h14);

    stall = `STALL_BRANCH;
    tick(); chk_pc("br_hold1", 32'h14);
    tick(); stall = `STALL_NONE; chk_pc("br_hold2", 32'h14);
    tick(); chk_pc("br_release", 32'h18);

    stall = 2'd3;
    tick(); stall = `STALL_NONE; chk_pc("other_stall", 32'h1C);

    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1 check("redir_flush", {31'h0, flush}, 32'h1);
    check("redir_contract", {31'h0, stall_viol}, 32'h0);
    tick(); redirect_valid = 1'b0;
    chk_pc("redir_40", 32'h40);
    check("flush_low", {31'h0, flush}, 32'h0);

    redirect_valid = 1'b1; redirect_pc = 32'h203;
    #1 check("redir203_flush", {31'h0, flush}, 32'h1);
    tick(); redirect_valid = 1'b0;
    chk_pc("redir_200", 32'h200);

    redirect_valid = 1'b1; redirect_pc = 32'h104; stall = `STALL_LOAD;
    #1 check("redir_stall_flush", {31'h0, flush}, 32'h1);
    check("redir_stall_contract", {31'h0, stall_viol}, 32'h1);
    tick(); redirect_valid = 1'b0; stall = `STALL_NONE;
    chk_pc("redir_stall_pc", 32'h104);

    upd(32'h20, 1'b1, 32'h80);
    chk_pc("after_alloc", 32'h108);
    go(32'h20);
    chk_bp("alloc_pred", 1'b1, 32'h80);
    tick(); chk_pc("alloc_jump", 32'h80);
    chk_bp("at_target", 1'b0, 32'h0);

    go(32'h20);
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b0; upd_target = 32'h0;
    chk_bp("collision", 1'b1, 32'h80);
    tick(); upd_valid = 1'b0;
    chk_pc("collision_jump", 32'h80);
    go(32'h20);
    chk_bp("weak_nt", 1'b0, 32'h0);
    tick(); chk_pc("weak_nt_seq", 32'h24);

    for (int i = 0; i < 4; i++) upd(32'h20, 1'b1, 32'h80);
    upd(32'h20, 1'b0, 32'h0);
    go(32'h20);
    chk_bp("sat_pred", 1'b1, 32'h80);
    tick(); chk_pc("sat_jump", 32'h80);

    upd(32'h60, 1'b1, 32'h300);
    go(32'h20);
    chk_bp("alias_evict", 1'b0, 32'h0);
    tick(); chk_pc("alias_seq", 32'h24);
    go(32'h60);
    chk_bp("alias_new", 1'b1, 32'h300);

    upd(32'h20, 1'b0, 32'h0);
    go(32'h60);
    chk_bp("miss_nt_nochg", 1'b1, 32'h300);

    go(32'hFFFF_FFFC);
    chk_pc("wrap_top", 32'hFFFF_FFFC);
    tick(); chk_pc("wrap_zero", 32'h0);

    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h60; upd_taken = 1'b1; upd_target = 32'h500;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    rst = 1'b0; upd_valid = 1'b0; redirect_valid = 1'b0;
    chk_pc("rst_override", 32'h0);
    go(32'h60);
    chk_bp("rst_clears_btb", 1'b0, 32'h0);
    tick(); chk_pc("rst_seq", 32'h64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
